// File: rtl/aes_ultraserial_arbiter.sv
// aes_ultraserial_arbiter: round-robin sharing of one aes_core_ultraserial between requesters A and B.
// Define AES_ARB_TIMEOUT_EN to build the start-to-completion watchdog.
module aes_ultraserial_arbiter #(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_req_valid,
  output logic         a_req_ready,
  input  logic         a_enc_dec,
  input  logic [127:0] a_key,
  input  logic [127:0] a_data,
  output logic         a_resp_valid,
  input  logic         a_resp_ready,
  input  logic         b_req_valid,
  output logic         b_req_ready,
  input  logic         b_enc_dec,
  input  logic [127:0] b_key,
  input  logic [127:0] b_data,
  output logic         b_resp_valid,
  input  logic         b_resp_ready,
  output logic [127:0] resp_data,
  output logic         resp_err,
  output logic         core_start,
  output logic         core_enc_dec,
  output logic [127:0] core_key,
  output logic [127:0] core_data,
  input  logic [127:0] core_out,
  input  logic         core_ready,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;
  state_t       state_q, state_d;
  logic         owner_q, owner_d, rr_q, rr_d, dir_q, dir_d;
  logic [127:0] key_q, key_d, data_q, data_d, resp_q, resp_d;
  logic         grant, pick_b, done;
  assign grant  = state_q == IDLE && core_ready && (a_req_valid || b_req_valid);
  assign pick_b = b_req_valid && (!a_req_valid || rr_q);
  assign done   = state_q == RESP && (owner_q ? b_resp_ready : a_resp_ready);
`ifdef AES_ARB_TIMEOUT_EN
  logic [11:0] cnt_q, cnt_d;
  logic        err_q, err_d, waiting, wd_hit;
  assign waiting  = state_q == WAIT_BUSY || state_q == WAIT_DONE;
  // cnt_q lags the ISSUE cycle by one, so this lands RESP exactly TIMEOUT_CYCLES after ISSUE
  assign wd_hit   = waiting && cnt_q == 12'(TIMEOUT_CYCLES - 2);
  assign resp_err = err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign resp_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      dir_q   <= 1'b1;
      key_q   <= '0;
      data_q  <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      dir_q   <= dir_d;
      key_q   <= key_d;
      data_q  <= data_d;
      resp_q  <= resp_d;
    end
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    dir_d   = dir_q;
    key_d   = key_q;
    data_d  = data_q;
    resp_d  = resp_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = ISSUE;
        owner_d = pick_b;
        rr_d    = !pick_b;
        dir_d   = pick_b ? b_enc_dec : a_enc_dec;
        key_d   = pick_b ? b_key : a_key;
        data_d  = pick_b ? b_data : a_data;
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!core_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (core_ready) begin
        state_d = RESP;
        resp_d  = core_out;
      end
      RESP:      if (done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
`ifdef AES_ARB_TIMEOUT_EN
    cnt_d = state_q == ISSUE ? '0 : waiting ? cnt_q + 1'b1 : cnt_q;
    err_d = state_q == WAIT_DONE && core_ready ? 1'b0 : err_q;
    if (wd_hit) begin
      state_d = RESP;
      resp_d  = '0;
      err_d   = 1'b1;
    end
`endif
  end
  always_comb begin
    a_req_ready  = grant && !pick_b;
    b_req_ready  = grant && pick_b;
    core_start   = state_q == ISSUE;
    busy         = state_q != IDLE;
    a_resp_valid = state_q == RESP && !owner_q;
    b_resp_valid = state_q == RESP && owner_q;
  end
  assign core_enc_dec = dir_q;
  assign core_key     = key_q;
  assign core_data    = data_q;
  assign resp_data    = resp_q;
endmodule

// File: doc/aes_ultraserial_arbiter.md
# aes_ultraserial_arbiter

Shares one `aes_core_ultraserial` instance between two independent requesters, A and B.
- Accepts a request from either side on a valid/ready handshake and latches its key, data and direction.
- Sequences the core through its start/ready protocol and returns the result to the granted requester.
- Arbitrates with a round-robin pointer, so a continuously requesting port cannot starve the other.
- Sits directly between the requester logic and the core's `start/enc_dec/data_in/key_in/data_out/ready` ports.

## Interface
- `TIMEOUT_CYCLES`, 2048: watchdog limit in cycles, from the start pulse to core completion. Used only when `AES_ARB_TIMEOUT_EN` is defined.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `a_req_valid`, `b_req_valid`  in  1  the requester holds a request.
- `a_req_ready`, `b_req_ready`  out  1  request accepted this cycle.
- `a_enc_dec`, `b_enc_dec`  in  1  1 = encrypt, 0 = decrypt.
- `a_key`, `b_key`  in  128  cipher key.
- `a_data`, `b_data`  in  128  plaintext or ciphertext.
- `a_resp_valid`, `b_resp_valid`  out  1  result available.
- `a_resp_ready`, `b_resp_ready`  in  1  requester consumes the result.
- `resp_data`  out  128  result; shared by both ports, qualified by the matching `*_resp_valid`.
- `resp_err`  out  1  result aborted by the watchdog.
- `core_start`  out  1  one-cycle start pulse to the core.
- `core_enc_dec`  out  1  direction driven to the core.
- `core_key`  out  128  key driven to the core.
- `core_data`  out  128  data driven to the core.
- `core_out`  in  128  core `data_out`.
- `core_ready`  in  1  core `ready`; high when the core is idle or done.
- `busy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- **IDLE:**
  - Wait for `core_ready`=1 and at least one `*_req_valid`=1.
  - If only one port is valid, grant it.
  - If both are valid, grant the port named by `rr_ptr` (reset value A).
  - On a grant:
    - pulse the granted `*_req_ready` for exactly one cycle;
    - latch that port's key, data and enc_dec into the `core_*` registers;
    - record the owner;
    - set `rr_ptr` to the other port;
    - go to ISSUE.
- **ISSUE:** assert `core_start` for one cycle, then go to WAIT_BUSY.
- **WAIT_BUSY:** wait for `core_ready`=0, then go to WAIT_DONE. A core that never drops `ready` is caught only by the watchdog.
- **WAIT_DONE:** on `core_ready`=1:
  - latch `core_out` into `resp_data`;
  - clear `resp_err`;
  - go to RESP.
- **RESP:**
  - Hold the owner's `*_resp_valid`=1 and `resp_data` stable until that port's `*_resp_ready`=1.
  - On that cycle, drop `*_resp_valid` and go to IDLE.
  - A new request is not granted in the same cycle.
- **Stability of core inputs:** `core_key`, `core_data` and `core_enc_dec` change only on a grant. They stay stable from ISSUE until return to IDLE.
- **Backpressure:** a request that arrives while the block is not in IDLE waits. `*_req_ready` stays 0 outside IDLE.
- **`*_resp_ready` outside RESP:** ignored.
- **Non-owner `*_resp_valid`:** held at 0 throughout.

## Timing
- **Reset values:**
  - state = IDLE;
  - all `*_req_ready`, `*_resp_valid`, `core_start`, `resp_err` and `busy` = 0;
  - `resp_data`, `core_key` and `core_data` = 0;
  - `core_enc_dec` = 1;
  - `rr_ptr` = A.
- **Reset mid-operation:**
  - all state returns to IDLE asynchronously;
  - any pending result is discarded;
  - `core_start` is not reasserted until a new grant.
- **Latency:** `*_req_ready` is asserted in the first IDLE cycle in which `*_req_valid` and `core_ready` are both 1.
- **Start pulse:** `core_start` is asserted exactly 1 cycle after the `*_req_ready` pulse.
- **Result:** `*_resp_valid` rises 1 cycle after `core_ready` is seen high in WAIT_DONE.
- **Overhead:** total arbiter overhead is 3 cycles plus the core latency.
- **Fairness:** when both ports request continuously, grants alternate A, B, A, B.
- **Simultaneous events:**
  - a request arriving in the cycle RESP completes is granted on the next IDLE cycle;
  - `rr_ptr` is updated only on a grant.

## Configuration
- **`AES_ARB_TIMEOUT_EN` defined:**
  - a 12-bit counter clears on ISSUE and increments in WAIT_BUSY and WAIT_DONE;
  - when the counter reaches `TIMEOUT_CYCLES`, the block goes to RESP with `resp_err`=1 and `resp_data`=0;
  - the next grant additionally waits for `core_ready`=1.
- **Not defined:**
  - no counter is built;
  - `resp_err` is constant 0;
  - WAIT_BUSY and WAIT_DONE wait indefinitely.

## Test plan
- **Single encrypt:**
  - Stimulus: A requests enc, key `000102030405060708090a0b0c0d0e0f`, data `00112233445566778899aabbccddeeff`.
  - Required: `a_resp_valid` with `resp_data`=`69c4e0d86a7b0430d8cdb78070b4c55a`, `resp_err`=0; `b_resp_valid` stays 0.
- **Single decrypt:**
  - Stimulus: B requests dec, key `2b7e151628aed2a6abf7158809cf4f3c`, data `3925841d02dc09fbdc118597196a0b32`.
  - Required: `b_resp_valid` with `resp_data`=`3243f6a8885a308d313198a2e0370734`.
- **Fairness:**
  - Stimulus: A and B both assert valid in the same cycle, back to back for 4 transactions with all-zero key/data, enc.
  - Required: grant order A, B, A, B; every result = `66e94bd4ef8a2c3b884cfa59ca342b2e`.
- **Backpressure:**
  - Stimulus: hold `a_resp_ready`=0 for 20 cycles after `a_resp_valid` rises, with B requesting meanwhile.
  - Required: `resp_data` stable; `b_req_ready`=0; `core_start`=0 until A consumes the result; B is granted on the next cycle.
- **Reset mid-operation:**
  - Stimulus: drop `rst_n` during WAIT_DONE.
  - Required: all outputs at reset values immediately; no `*_resp_valid` after release; a new request completes correctly.
- **Watchdog (`AES_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=64):**
  - Stimulus: stub core holds `core_ready`=0 forever after the start pulse.
  - Required: `a_resp_valid` with `resp_err`=1 and `resp_data`=0 exactly 64 cycles after ISSUE.
